// File: rtl/flare32_mem_responder_if.sv
// Request/response handshake bundle between a Flare32 initiator and the memory responder.
interface flare32_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/flare32_mem_responder.sv
// Flare32 memory responder: one outstanding byte/half/word access with programmable wait states.
// Optional misalignment errors enabled by defining FLARE32_MEM_ALIGN_CHECK_EN.
module flare32_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst,
    flare32_mem_responder_if.slave bus
);
    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]            cnt;
    logic                  lat_we;
    logic [1:0]            lat_size;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic [31:0] mem [2**WORD_BITS];

    logic                  accept;
    logic                  do_access;
    logic                  a_we;
    logic [1:0]            a_size;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [31:0]           a_wdata;
    logic [1:0]            lane;
    logic [WORD_BITS-1:0]  a_idx;
    logic [3:0]            be;
    logic [31:0]           wshift;
    logic [31:0]           rword;
    logic [31:0]           rsel;
    logic                  misaligned;
    logic                  unused_addr;

    assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH];

    assign accept    = (state == S_IDLE) && bus.req_valid;
    assign do_access = (accept && WAIT_STATES == 0)
                     || (state == S_WAIT && cnt == 4'd1);

    // Zero wait states access straight from the bus on the accept edge.
    always_comb begin
        if (state == S_IDLE) begin
            a_we    = bus.req_we;
            a_size  = bus.req_size;
            a_addr  = bus.req_addr[ADDR_WIDTH-1:0];
            a_wdata = bus.req_wdata;
        end else begin
            a_we    = lat_we;
            a_size  = lat_size;
            a_addr  = lat_addr;
            a_wdata = lat_wdata;
        end
    end

    assign lane  = a_addr[1:0];
    assign a_idx = a_addr[ADDR_WIDTH-1:2];
    assign rword = mem[a_idx];

`ifdef FLARE32_MEM_ALIGN_CHECK_EN
    assign misaligned = (a_size == 2'd1 && lane[0])
                      || (a_size[1] && lane != 2'd0);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be     = 4'h0;
        wshift = 32'h0;
        rsel   = 32'h0;
        unique case (1'b1)
            (a_size == 2'd0): begin
                be     = 4'b0001 << lane;
                wshift = a_wdata << {lane, 3'b000};
                rsel   = {24'h0, 8'(rword >> {lane, 3'b000})};
            end
            (a_size == 2'd1): begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wshift = lane[1] ? {a_wdata[15:0], 16'h0}
                                 : {16'h0, a_wdata[15:0]};
                rsel   = {16'h0, lane[1] ? rword[31:16] : rword[15:0]};
            end
            default: begin
                be     = 4'hf;
                wshift = a_wdata;
                rsel   = rword;
            end
        endcase
        if (misaligned) begin
            be   = 4'h0;
            rsel = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.req_valid)
                        state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt == 4'd1) state_nxt = S_RESP;
            S_RESP: if (bus.resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state)
            S_IDLE:  bus.req_ready  = 1'b1;
            S_RESP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_size  <= bus.req_size;
                lat_addr  <= bus.req_addr[ADDR_WIDTH-1:0];
                lat_wdata <= bus.req_wdata;
                cnt       <= WS;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rdata_q <= a_we ? 32'h0 : rsel;
                err_q   <= misaligned;
            end
        end
    end

    // Reset wins over the access edge, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (!rst && do_access && a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[a_idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
